// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and types for the operand fetch stage.
// Register bank geometry, scoreboard widths and the output slot bundle.
package operand_fetch_stage_pkg;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 2;
    localparam int SUM_W  = CNT_W + 1;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [OP_W-1:0] op;
        addr_t           rd;
        logic            wr_rd;
        data_t           a;
        data_t           b;
    } slot_t;

    // A source stalls unless at most one write is pending
    // and that write lands this very cycle.
    function automatic logic src_hazard(
        input cnt_t cnt,
        input logic wb_hit
    );
        return (cnt >= cnt_t'(2)) ||
               ((cnt == cnt_t'(1)) && !wb_hit);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Per-register count of issued but not yet written-back writes.
// Flush decrements that would go negative clamp and raise a sticky flag.
module reg_scoreboard_16
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              fl_en,
    input  logic [ADDR_W-1:0] fl_addr,
    input  logic [ADDR_W-1:0] q0_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] qd_addr,
    output logic [CNT_W-1:0]  q0_cnt,
    output logic [CNT_W-1:0]  q1_cnt,
    output logic [CNT_W-1:0]  qd_cnt,
    output logic              underflow
);

    cnt_t             cnt_q [NREGS];
    cnt_t             cnt_d [NREGS];
    logic [SUM_W-1:0] sum_v [NREGS];
    logic             uf_q;
    logic             uf_d;

    assign q0_cnt    = cnt_q[q0_addr];
    assign q1_cnt    = cnt_q[q1_addr];
    assign qd_cnt    = cnt_q[qd_addr];
    assign underflow = uf_q;

    // Sum all inc/dec terms per register; a negative sum clamps to zero.
    always_comb begin
        uf_d = uf_q;
        for (int r = 0; r < NREGS; r++) begin
            sum_v[r] = SUM_W'(cnt_q[r])
                     + SUM_W'(inc_en && (inc_addr == addr_t'(r)))
                     - SUM_W'(wb_en && (wb_addr == addr_t'(r))
                              && (cnt_q[r] != '0))
                     - SUM_W'(fl_en && (fl_addr == addr_t'(r)));
            if (sum_v[r][SUM_W-1]) begin
                cnt_d[r] = '0;
                uf_d     = 1'b1;
            end else begin
                cnt_d[r] = sum_v[r][CNT_W-1:0];
            end
        end
    end

    // Counter and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            uf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register bank, bypasses writeback data,
// stalls on pending writes and hands operands to execute via valid/ready.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs0,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wr_rd,
    output logic [ADDR_W-1:0] raddr0,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wr_rd,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              sb_underflow
);

    slot_t slot_q;
    slot_t slot_d;
    logic  valid_q;
    logic  valid_d;

    cnt_t  cnt0;
    cnt_t  cnt1;
    cnt_t  cntd;

    logic  hit0;
    logic  hit1;
    logic  hitd;
    logic  hazard;
    logic  slot_free;
    logic  accept;
    logic  fl_kill;
    data_t opa;
    data_t opb;

    assign raddr0 = in_rs0;
    assign raddr1 = in_rs1;

    // Hazard detection, handshake and write-bypass operand select.
    always_comb begin
        hit0      = wb_we && (wb_addr == in_rs0);
        hit1      = wb_we && (wb_addr == in_rs1);
        hitd      = wb_we && (wb_addr == in_rd);
        hazard    = src_hazard(cnt0, hit0)
                 || src_hazard(cnt1, hit1)
                 || (in_wr_rd && (cntd == CNT_MAX) && !hitd);
        slot_free = !valid_q || out_ready;
        in_ready  = slot_free && !hazard && !flush;
        accept    = in_valid && in_ready;
        fl_kill   = flush && valid_q && slot_q.wr_rd;
        opa       = hit0 ? wb_data : rdata0;
        opb       = hit1 ? wb_data : rdata1;
    end

    // Output slot: load on accept, hold while stalled, drop on flush.
    always_comb begin
        valid_d = accept || (valid_q && !out_ready && !flush);
        slot_d  = slot_q;
        if (accept) begin
            slot_d.op    = in_op;
            slot_d.rd    = in_rd;
            slot_d.wr_rd = in_wr_rd;
            slot_d.a     = opa;
            slot_d.b     = opb;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    reg_scoreboard_16 u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (accept && in_wr_rd),
        .inc_addr  (in_rd),
        .wb_en     (wb_we),
        .wb_addr   (wb_addr),
        .fl_en     (fl_kill),
        .fl_addr   (slot_q.rd),
        .q0_addr   (in_rs0),
        .q1_addr   (in_rs1),
        .qd_addr   (in_rd),
        .q0_cnt    (cnt0),
        .q1_cnt    (cnt1),
        .qd_cnt    (cntd),
        .underflow (sb_underflow)
    );

    assign out_valid = valid_q;
    assign out_op    = slot_q.op;
    assign out_rd    = slot_q.rd;
    assign out_wr_rd = slot_q.wr_rd;
    assign out_a     = slot_q.a;
    assign out_b     = slot_q.b;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage with a behavioural bank,
// directed scenarios and a randomized phase against a reference model.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_op = '0;
    logic [ADDR_W-1:0] in_rs0 = '0;
    logic [ADDR_W-1:0] in_rs1 = '0;
    logic [ADDR_W-1:0] in_rd = '0;
    logic              in_wr_rd = 1'b0;
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              wb_we = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_rd;
    logic              out_wr_rd;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              sb_underflow;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs0(in_rs0), .in_rs1(in_rs1),
        .in_rd(in_rd), .in_wr_rd(in_wr_rd),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_wr_rd(out_wr_rd),
        .out_a(out_a), .out_b(out_b),
        .sb_underflow(sb_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural register bank: async read, write at the clock edge.
    logic [DATA_W-1:0] bank [NREGS];
    assign rdata0 = bank[raddr0];
    assign rdata1 = bank[raddr1];
    always @(posedge clk) begin
        if (wb_we) bank[wb_addr] <= wb_data;
    end

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state.
    int   mcnt [NREGS];
    bit   mv;
    bit   mwr;
    int   mrd;
    bit   muf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit pend_stall(int c, bit wbhit);
        if (c >= 2) return 1;
        if (c == 1 && !wbhit) return 1;
        return 0;
    endfunction

    // One cycle: drive inputs, check against model, advance the model.
    task automatic drive(
        input bit v, input int op, input int s0, input int s1,
        input int d, input bit w, input bit we, input int wa,
        input int wd, input bit ordy, input bit fl, input bit r,
        output bit rdy_seen
    );
        bit rdy;
        bit acc;
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_op     = OP_W'(op);
        in_rs0    = ADDR_W'(s0);
        in_rs1    = ADDR_W'(s1);
        in_rd     = ADDR_W'(d);
        in_wr_rd  = w;
        wb_we     = we;
        wb_addr   = ADDR_W'(wa);
        wb_data   = DATA_W'(wd);
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_seen = in_ready;
        if (r) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            mv = 0;
            muf = 0;
            exp_q.delete();
            return;
        end
        rdy = (!mv || ordy) && !fl
            && !pend_stall(mcnt[s0], we && wa == s0)
            && !pend_stall(mcnt[s1], we && wa == s1)
            && !(w && mcnt[d] == 3 && !(we && wa == d));
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("sb_underflow", 32'(sb_underflow), 32'(muf));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("raddr0", 32'(raddr0), 32'(s0));
        acc = v && rdy;
        if (acc) begin
            e.op = OP_W'(op);
            e.rd = ADDR_W'(d);
            e.wr = w;
            e.a  = (we && wa == s0) ? DATA_W'(wd) : bank[s0];
            e.b  = (we && wa == s1) ? DATA_W'(wd) : bank[s1];
            exp_q.push_back(e);
        end
        for (int i = 0; i < NREGS; i++) begin
            int n;
            n = mcnt[i];
            if (acc && w && d == i) n++;
            if (we && wa == i && mcnt[i] > 0) n--;
            if (fl && mv && mwr && mrd == i) n--;
            if (n < 0) begin
                n = 0;
                muf = 1;
            end
            mcnt[i] = n;
        end
        if (acc) begin
            mv = 1;
            mrd = d;
            mwr = w;
        end else if (fl || ordy) begin
            mv = 0;
        end
    endtask

    // Monitor: consume or drop the held instruction at each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && (flush || out_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!flush) begin
                        chk("out_op", 32'(out_op), 32'(e.op));
                        chk("out_rd", 32'(out_rd), 32'(e.rd));
                        chk("out_wr_rd", 32'(out_wr_rd), 32'(e.wr));
                        chk("out_a", 32'(out_a), 32'(e.a));
                        chk("out_b", 32'(out_b), 32'(e.b));
                    end
                end
            end
        end
    end

    initial begin
        bit rd_y;
        logic [DATA_W-1:0] ha;
        logic [OP_W-1:0] hop;
        foreach (mcnt[i]) mcnt[i] = 0;
        mv = 0; mwr = 0; mrd = 0; muf = 0;

        drive(0,0,0,0,0,0, 0,0,0, 0,0,1, rd_y);
        drive(0,0,0,0,0,0, 0,0,0, 0,0,1, rd_y);
        drive(0,0,0,0,0,0, 0,0,0, 0,0,0, rd_y);
        chk("rst_in_ready", 32'(rd_y), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);

        for (int i = 0; i < NREGS; i++)
            drive(0,0,0,0,0,0, 1,i,$urandom_range(0,20'hFFFFF), 0,0,0, rd_y);
        drive(0,0,0,0,0,0, 1,3,20'h0ABCD, 0,0,0, rd_y);
        drive(0,0,0,0,0,0, 1,5,20'h00012, 0,0,0, rd_y);

        drive(1,8'h11,3,5,7,1, 0,0,0, 1,0,0, rd_y);
        chk("issue_r3_r5", 32'(rd_y), 32'd1);
        drive(1,8'h22,7,0,1,0, 0,0,0, 1,0,0, rd_y);
        chk("raw_stall", 32'(rd_y), 32'd0);
        chk("first_a", 32'(out_a), 32'h0ABCD);
        chk("first_b", 32'(out_b), 32'h00012);
        chk("first_rd", 32'(out_rd), 32'd7);
        drive(1,8'h22,7,0,1,0, 1,7,20'hFFFFF, 1,0,0, rd_y);
        chk("wb_release", 32'(rd_y), 32'd1);
        drive(1,8'h33,7,7,8,0, 0,0,0, 1,0,0, rd_y);
        chk("bypass_a", 32'(out_a), 32'hFFFFF);
        chk("cnt7_zero", 32'(rd_y), 32'd1);

        for (int i = 0; i < 3; i++) begin
            drive(1,8'h40+i,0,0,2,1, 0,0,0, 1,0,0, rd_y);
            chk("r2_write", 32'(rd_y), 32'd1);
        end
        drive(1,8'h44,0,0,2,1, 0,0,0, 1,0,0, rd_y);
        chk("r2_dest_stall", 32'(rd_y), 32'd0);
        drive(1,8'h44,0,0,2,1, 1,2,20'h12345, 1,0,0, rd_y);
        chk("r2_dest_wb", 32'(rd_y), 32'd1);
        drive(1,8'h45,0,0,2,1, 0,0,0, 1,0,0, rd_y);
        chk("r2_still_max", 32'(rd_y), 32'd0);

        drive(1,8'h90,1,4,9,1, 0,0,0, 1,0,0, rd_y);
        chk("issue_r9", 32'(rd_y), 32'd1);
        drive(1,8'h91,0,0,1,0, 0,0,0, 0,0,0, rd_y);
        ha = out_a;
        hop = out_op;
        for (int i = 0; i < 4; i++) begin
            drive(1,8'h91,0,0,1,0, 0,0,0, 0,0,0, rd_y);
            chk("hold_ready", 32'(rd_y), 32'd0);
            chk("hold_a", 32'(out_a), 32'(ha));
            chk("hold_op", 32'(out_op), 32'(hop));
        end
        drive(0,0,0,0,0,0, 0,0,0, 1,1,0, rd_y);
        chk("flush_ready", 32'(rd_y), 32'd0);
        drive(1,8'h92,9,9,3,0, 0,0,0, 1,0,0, rd_y);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_uf", 32'(sb_underflow), 32'd0);
        chk("cnt9_zero", 32'(rd_y), 32'd1);

        drive(1,8'hA0,0,0,4,1, 0,0,0, 1,0,0, rd_y);
        drive(1,8'hA1,4,0,5,1, 0,0,0, 1,0,0, rd_y);
        chk("pre_rst_stall", 32'(rd_y), 32'd0);
        drive(1,8'hA1,4,0,5,1, 0,0,0, 1,0,1, rd_y);
        drive(0,0,0,0,0,0, 0,0,0, 1,0,0, rd_y);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        drive(1,8'hA2,4,2,6,0, 0,0,0, 1,0,0, rd_y);
        chk("rst_mid_cnt", 32'(rd_y), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            int wa;
            int st;
            bit we;
            we = $urandom_range(0, 1);
            wa = $urandom_range(0, NREGS-1);
            if ($urandom_range(0, 3) != 0) begin
                st = $urandom_range(0, NREGS-1);
                for (int k = 0; k < NREGS; k++) begin
                    if (mcnt[(st + k) % NREGS] > 0) begin
                        wa = (st + k) % NREGS;
                        break;
                    end
                end
            end
            drive($urandom_range(0,9) < 7, $urandom_range(0,255),
                  $urandom_range(0,NREGS-1), $urandom_range(0,NREGS-1),
                  $urandom_range(0,NREGS-1), $urandom_range(0,9) < 6,
                  we, wa, $urandom_range(0,20'hFFFFF),
                  $urandom_range(0,9) < 7, $urandom_range(0,19) == 0,
                  0, rd_y);
        end

        for (int i = 0; i < 4; i++)
            drive(0,0,0,0,0,0, 0,0,0, 1,0,0, rd_y);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the 16x20 register bank.
- Accepts decoded instructions and drives the bank's two read addresses. Captures both read words into a registered output slot.
- Forwards same-cycle writeback data and tracks in-flight destination writes with a per-register scoreboard.
- Stalls the decoder on read-after-write hazards and presents operands to the execute stage over a valid/ready handshake.

Parameters:
DATA_W, 20, register word width
ADDR_W, 4, register address width
NREGS, 16, register count (2**ADDR_W)
OP_W, 8, opaque decoded-op field carried through
CNT_W, 2, scoreboard counter width per register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  kill the instruction held in the output slot
in_valid  in  1  decoder has an instruction
in_ready  out  1  stage accepts instruction this cycle
in_op  in  OP_W  decoded op
in_rs0  in  ADDR_W  source register 0
in_rs1  in  ADDR_W  source register 1
in_rd  in  ADDR_W  destination register
in_wr_rd  in  1  instruction will write in_rd
raddr0  out  ADDR_W  bank read address 0 (= in_rs0, combinational)
raddr1  out  ADDR_W  bank read address 1 (= in_rs1, combinational)
rdata0  in  DATA_W  bank read data 0 (combinational from raddr0)
rdata1  in  DATA_W  bank read data 1
wb_we  in  1  writeback this cycle (same signal driving bank WE)
wb_addr  in  ADDR_W  writeback address
wb_data  in  DATA_W  writeback data
out_valid  out  1  output slot holds an instruction
out_ready  in  1  execute stage consumes
out_op  out  OP_W
out_rd  out  ADDR_W
out_wr_rd  out  1
out_a  out  DATA_W  operand for rs0
out_b  out  DATA_W  operand for rs1
sb_underflow  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset:
  - out_valid=0; out_op/out_rd/out_wr_rd/out_a/out_b=0.
  - All scoreboard counters 0; sb_underflow=0.
  - Reset mid-stall discards the held instruction with no writeback.
- Scoreboard: cnt[r] is the number of issued, not-yet-written-back writes to register r.
- Source hazard on rs:
  - cnt[rs]>=2 -> stall.
  - cnt[rs]==1 and not (wb_we && wb_addr==rs) -> stall.
  - cnt[rs]==1 with a matching writeback, or cnt[rs]==0 -> no stall.
- Destination hazard: in_wr_rd && cnt[in_rd]==max (3) && no writeback to in_rd this cycle.
- slot_free = !out_valid || out_ready.
- in_ready = slot_free && !hazard(rs0) && !hazard(rs1) && !dest_hazard && !flush.
- Accept = in_valid && in_ready. Latency 1 cycle: out_* registered on the next edge.
- Operand select per source: wb_we && wb_addr==rs -> wb_data (write-bypass); otherwise rdata. Applies even when cnt==0.
- The output slot holds steady while out_valid && !out_ready.
- out_valid update: next = accept, or (out_valid && !out_ready && !flush).
- Counter update per register r, all terms summed:
  - +1 if accept && in_wr_rd && in_rd==r.
  - -1 if wb_we && wb_addr==r && cnt[r]>0.
  - -1 if flush && out_valid && out_wr_rd && out_rd==r.
  - Simultaneous +1/-1 on the same register -> unchanged.
- wb_we to a register with cnt==0: counter stays 0, no error (initialisation writes).
- Flush decrement that would take a counter below 0: clamp at 0 and set sb_underflow. sb_underflow clears only on rst.
- Flush with out_ready high in the same cycle: flush wins, the instruction is not counted as delivered.
- rs0==rs1 is legal; both operands get identical values.
- in_rd equal to in_rs0 or in_rs1 is legal: hazards are checked before the increment.

Decomposition:
- Shared package: DATA_W, ADDR_W, NREGS, CNT_W constants; the scoreboard counter max value.
- One natural sub-module: reg_scoreboard_16. Holds the 16 counters, computes inc/dec/clamp, exposes pending-count reads for rs0/rs1/rd.

Test Plan:
- rst high 2 cycles, then idle -> out_valid=0, all counters 0, in_ready=1.
- Bank R3=0x0ABCD, R5=0x00012; issue rs0=3, rs1=5, rd=7, wr_rd=1, out_ready=1 -> next cycle out_a=0x0ABCD, out_b=0x00012, out_rd=7; cnt[7]=1.
- Then issue rs0=7 with no writeback -> in_ready=0 (stall). Next cycle wb_we=1, wb_addr=7, wb_data=0xFFFFF -> in_ready=1, out_a=0xFFFFF, cnt[7]=0.
- Issue 3 writes to R2 with no writeback, then a 4th -> 4th stalls. Then wb to R2 -> 4th accepted that cycle, cnt[2] stays 3.
- Hold out_ready=0 with out_valid=1 for 4 cycles -> out_* stable, in_ready=0. Assert flush with out_wr_rd=1, out_rd=9, cnt[9]=1 -> out_valid=0, cnt[9]=0, sb_underflow=0.
- Assert rst while in_valid=1 and stalled -> next cycle out_valid=0, all counters 0, no spurious out_valid.
